// File: rtl/ahb3lite_apb_bridge.sv
// AHB3-Lite slave to APB master bridge: one blocking transfer in flight,
// AHB wait states cover the whole APB latency.
module ahb3lite_apb_bridge #(
    parameter int unsigned HADDR_SIZE = 32,
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned PADDR_SIZE = 8
) (
    input  logic                    HCLK,
    input  logic                    HRESET,
    input  logic                    HSEL,
    input  logic [HADDR_SIZE-1:0]   HADDR,
    input  logic [DATA_SIZE-1:0]    HWDATA,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [1:0]              HTRANS,
    input  logic [3:0]              HPROT,
    input  logic                    HREADY,
    output logic                    HREADYOUT,
    output logic                    HRESP,
    output logic [DATA_SIZE-1:0]    HRDATA,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic [PADDR_SIZE-1:0]   PADDR,
    output logic                    PWRITE,
    output logic [DATA_SIZE/8-1:0]  PSTRB,
    output logic [2:0]              PPROT,
    output logic [DATA_SIZE-1:0]    PWDATA,
    input  logic [DATA_SIZE-1:0]    PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int unsigned STRB_SIZE = DATA_SIZE / 8;
    localparam int unsigned LANE_BITS = $clog2(STRB_SIZE);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t                  state, state_nxt;
    logic                    hreadyout_nxt, hresp_nxt, psel_nxt, penable_nxt, pwrite_nxt;
    logic [DATA_SIZE-1:0]    hrdata_nxt;
    logic [PADDR_SIZE-1:0]   paddr_nxt;
    logic [STRB_SIZE-1:0]    pstrb_nxt;
    logic [2:0]              pprot_nxt;
    logic                    may_accept;
    logic                    accept;
    logic                    size_ok;
    logic                    unused_inputs;

    // A lane is enabled when it falls in the same HSIZE-aligned block as the address
    function automatic logic [STRB_SIZE-1:0] write_strobe(input logic [2:0] size,
                                                          input logic [LANE_BITS-1:0] offset);
        logic [STRB_SIZE-1:0] strb;
        strb = '0;
        for (int unsigned i = 0; i < STRB_SIZE; i++) begin
            strb[i] = ((LANE_BITS'(i) >> size) == (offset >> size));
        end
        return strb;
    endfunction

    assign accept  = HSEL & HREADY & HTRANS[1];
    assign size_ok = (HSIZE <= 3'(LANE_BITS));
    assign PWDATA  = HWDATA;

    // Address bits above the APB window, SEQ/NONSEQ distinction and cache hints are not needed
    assign unused_inputs = ^{HADDR[HADDR_SIZE-1:PADDR_SIZE], HTRANS[0], HPROT[3:2]};

    // Next-state and next registered-output logic
    always_comb begin
        state_nxt     = state;
        hrdata_nxt    = HRDATA;
        paddr_nxt     = PADDR;
        pwrite_nxt    = PWRITE;
        pstrb_nxt     = PSTRB;
        pprot_nxt     = PPROT;
        may_accept    = 1'b0;
        hreadyout_nxt = 1'b1;
        hresp_nxt     = 1'b0;
        psel_nxt      = 1'b0;
        penable_nxt   = 1'b0;

        case (state)
            ST_IDLE:   may_accept = 1'b1;
            ST_SETUP:  state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (PREADY) begin
                    if (PSLVERR) begin
                        state_nxt = ST_ERR1;
                    end else begin
                        state_nxt = ST_IDLE;
                        if (!PWRITE) hrdata_nxt = PRDATA;
                    end
                end
            end
            ST_ERR1:   state_nxt = ST_ERR2;
            ST_ERR2: begin
                state_nxt  = ST_IDLE;
                may_accept = 1'b1;
            end
            default:   state_nxt = ST_IDLE;
        endcase

        if (may_accept && accept) begin
            if (size_ok) begin
                state_nxt  = ST_SETUP;
                paddr_nxt  = HADDR[PADDR_SIZE-1:0];
                pwrite_nxt = HWRITE;
                pstrb_nxt  = HWRITE ? write_strobe(HSIZE, HADDR[LANE_BITS-1:0]) : '0;
                pprot_nxt  = {~HPROT[0], 1'b1, HPROT[1]};
            end else begin
                state_nxt  = ST_ERR1;
            end
        end

        case (state_nxt)
            ST_SETUP: begin
                hreadyout_nxt = 1'b0;
                psel_nxt      = 1'b1;
            end
            ST_ACCESS: begin
                hreadyout_nxt = 1'b0;
                psel_nxt      = 1'b1;
                penable_nxt   = 1'b1;
            end
            ST_ERR1: begin
                hreadyout_nxt = 1'b0;
                hresp_nxt     = 1'b1;
            end
            ST_ERR2:   hresp_nxt = 1'b1;
            default:   hreadyout_nxt = 1'b1;
        endcase
    end

    // State and output registers; reset abandons any APB transfer immediately
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            HREADYOUT <= 1'b1;
            HRESP     <= 1'b0;
            HRDATA    <= '0;
            PSEL      <= 1'b0;
            PENABLE   <= 1'b0;
            PADDR     <= '0;
            PWRITE    <= 1'b0;
            PSTRB     <= '0;
            PPROT     <= '0;
        end else begin
            state     <= state_nxt;
            HREADYOUT <= hreadyout_nxt;
            HRESP     <= hresp_nxt;
            HRDATA    <= hrdata_nxt;
            PSEL      <= psel_nxt;
            PENABLE   <= penable_nxt;
            PADDR     <= paddr_nxt;
            PWRITE    <= pwrite_nxt;
            PSTRB     <= pstrb_nxt;
            PPROT     <= pprot_nxt;
        end
    end

endmodule

// File: tb/tb_ahb3lite_apb_bridge.sv
// Self-checking bench for ahb3lite_apb_bridge: directed and randomized AHB
// transfers against a transaction-level model of the expected APB/AHB behaviour.
module tb_ahb3lite_apb_bridge;

    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [31:0] HWDATA;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [1:0]  HTRANS;
    logic [3:0]  HPROT;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;
    logic        PSEL;
    logic        PENABLE;
    logic [7:0]  PADDR;
    logic        PWRITE;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] exp_hrdata;

    ahb3lite_apb_bridge #(
        .HADDR_SIZE (32),
        .DATA_SIZE  (32),
        .PADDR_SIZE (8)
    ) dut (
        .HCLK      (HCLK),
        .HRESET    (HRESET),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HWDATA    (HWDATA),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HTRANS    (HTRANS),
        .HPROT     (HPROT),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRESP     (HRESP),
        .HRDATA    (HRDATA),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PADDR     (PADDR),
        .PWRITE    (PWRITE),
        .PSTRB     (PSTRB),
        .PPROT     (PPROT),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .PSLVERR   (PSLVERR)
    );

    always #5 HCLK = ~HCLK;

    // Single slave on the bus: bus-level ready is this slave's ready
    assign HREADY = HREADYOUT;

    // One AHB transfer, presented in the current cycle (which must be a ready cycle).
    // Returns in the completion cycle so a following call is back-to-back.
    task automatic do_xfer(input string tag, input logic [31:0] addr, input logic wr,
                           input logic [2:0] size, input logic [3:0] prot,
                           input logic [31:0] wdata, input int nwait,
                           input logic slverr, input logic [31:0] rdata);
        int         cycles, acc_cnt, nbytes, off, exp_cycles;
        logic       size_err, exp_err, saw_psel, saw_err1, done;
        logic [3:0] exp_strb;
        logic [2:0] exp_prot;
        size_err = (size > 3'd2);
        nbytes   = 1 << size;
        off      = (int'(addr % 4) / nbytes) * nbytes;
        exp_strb = wr ? 4'(((1 << nbytes) - 1) << off) : 4'h0;
        exp_prot = {~prot[0], 1'b1, prot[1]};
        exp_err  = size_err || slverr;
        exp_cycles = size_err ? 2 : (slverr ? nwait + 4 : nwait + 3);

        n_cmp++;
        if (HREADYOUT !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept: HREADYOUT=%b want 1", tag, HREADYOUT);
        end
        HSEL = 1'b1; HADDR = addr; HWRITE = wr; HSIZE = size; HPROT = prot; HTRANS = 2'b10;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HADDR = $urandom; HWRITE = 1'($urandom);
        HWDATA = wdata; PREADY = 1'b0; PSLVERR = 1'b0;
        cycles = 1; acc_cnt = 0; saw_psel = 1'b0; saw_err1 = 1'b0; done = 1'b0;
        while (!done) begin
            if (PSEL) saw_psel = 1'b1;
            if (PSEL) begin
                n_cmp++;
                if ({PADDR, PWRITE, PSTRB, PPROT, PWDATA} !== {addr[7:0], wr, exp_strb, exp_prot, wdata}) begin
                    n_fail++;
                    $display("FAIL %s apb_fields(en=%b): PADDR/PWRITE/PSTRB/PPROT/PWDATA=%h/%b/%h/%h/%h want %h/%b/%h/%h/%h",
                             tag, PENABLE, PADDR, PWRITE, PSTRB, PPROT, PWDATA,
                             addr[7:0], wr, exp_strb, exp_prot, wdata);
                end
            end
            if (PSEL && PENABLE) begin
                if (acc_cnt == nwait) begin
                    PREADY = 1'b1; PSLVERR = slverr; PRDATA = rdata;
                end else begin
                    PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
                end
                acc_cnt++;
            end else begin
                PREADY = 1'($urandom); PSLVERR = 1'($urandom); PRDATA = $urandom;
            end
            if (HREADYOUT === 1'b0 && HRESP === 1'b1) saw_err1 = 1'b1;
            if (HREADYOUT === 1'b1) begin
                done = 1'b1;
            end else if (cycles >= 60) begin
                n_fail++;
                $display("FAIL %s timeout: no HREADYOUT after %0d cycles", tag, cycles);
                done = 1'b1;
            end else begin
                @(posedge HCLK); #1;
                cycles++;
            end
        end
        PREADY = 1'b0; PSLVERR = 1'b0;
        if (!exp_err && !wr) exp_hrdata = rdata;

        n_cmp++;
        if (cycles !== exp_cycles) begin
            n_fail++;
            $display("FAIL %s latency: data phase %0d cycles want %0d", tag, cycles, exp_cycles);
        end
        n_cmp++;
        if ({HRESP, saw_err1} !== {exp_err, exp_err}) begin
            n_fail++;
            $display("FAIL %s response: HRESP=%b err1_seen=%b want %b/%b", tag, HRESP, saw_err1, exp_err, exp_err);
        end
        n_cmp++;
        if ({saw_psel, PSEL, PENABLE} !== {~size_err, 2'b00}) begin
            n_fail++;
            $display("FAIL %s psel: seen=%b end PSEL/PENABLE=%b%b want seen=%b end 00",
                     tag, saw_psel, PSEL, PENABLE, ~size_err);
        end
        n_cmp++;
        if (HRDATA !== exp_hrdata) begin
            n_fail++;
            $display("FAIL %s hrdata: %h want %h", tag, HRDATA, exp_hrdata);
        end
    endtask

    task automatic idle_cycles(input int n);
        HSEL = 1'b0; HTRANS = 2'b00;
        repeat (n) begin
            @(posedge HCLK); #1;
        end
    endtask

    task automatic test_reset();
        n_cmp++;
        if ({HREADYOUT, HRESP, HRDATA, PSEL, PENABLE, PADDR, PWRITE, PSTRB, PPROT} !==
            {1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 8'h0, 1'b0, 4'h0, 3'h0}) begin
            n_fail++;
            $display("FAIL reset_values: HREADYOUT=%b HRESP=%b HRDATA=%h PSEL=%b PENABLE=%b PADDR=%h PWRITE=%b PSTRB=%h PPROT=%h",
                     HREADYOUT, HRESP, HRDATA, PSEL, PENABLE, PADDR, PWRITE, PSTRB, PPROT);
        end
        HRESET = 1'b0;
        exp_hrdata = 32'h0;
        @(posedge HCLK); #1;
    endtask

    task automatic test_spec_cases();
        do_xfer("write_word", 32'h10, 1'b1, 3'd2, 4'h3, 32'hA5A5_1234, 0, 1'b0, 32'h0);
        do_xfer("read_wait3", 32'h24, 1'b0, 3'd2, 4'h1, 32'h1111_2222, 3, 1'b0, 32'hDEAD_BEEF);
        do_xfer("byte_wr_13", 32'h13, 1'b1, 3'd0, 4'h0, 32'h7700_0000, 0, 1'b0, 32'h0);
        do_xfer("half_wr_12", 32'h12, 1'b1, 3'd1, 4'h2, 32'h5566_0000, 1, 1'b0, 32'h0);
        do_xfer("read_slverr", 32'h30, 1'b0, 3'd2, 4'h1, 32'h0, 0, 1'b1, 32'hBAD0_BAD0);
        do_xfer("read_after_err", 32'h34, 1'b0, 3'd2, 4'h1, 32'h0, 0, 1'b0, 32'h0BAD_F00D);
    endtask

    task automatic test_size_error();
        do_xfer("hsize3", 32'h40, 1'b1, 3'd3, 4'h1, 32'hCAFE_0001, 0, 1'b0, 32'h0);
        do_xfer("accept_in_err2", 32'h44, 1'b1, 3'd2, 4'h1, 32'hCAFE_0002, 0, 1'b0, 32'h0);
        do_xfer("hsize3_read", 32'h48, 1'b0, 3'd3, 4'h1, 32'h0, 0, 1'b0, 32'hFFFF_FFFF);
        do_xfer("read_in_err2", 32'h4C, 1'b0, 3'd1, 4'h1, 32'h0, 2, 1'b0, 32'h1234_5678);
    endtask

    task automatic test_ignored();
        for (int i = 0; i < 6; i++) begin
            HSEL = 1'b1; HTRANS = {1'b0, 1'($urandom)}; HADDR = $urandom;
            HWRITE = 1'($urandom); HSIZE = 3'd2;
            @(posedge HCLK); #1;
            n_cmp++;
            if ({HREADYOUT, HRESP, PSEL} !== 3'b100) begin
                n_fail++;
                $display("FAIL ignored_%0d: HREADYOUT/HRESP/PSEL=%b%b%b want 100", i, HREADYOUT, HRESP, PSEL);
            end
        end
        HSEL = 1'b0; HTRANS = 2'b00;
    endtask

    task automatic test_random();
        logic [2:0] size;
        for (int i = 0; i < 60; i++) begin
            size = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
            do_xfer($sformatf("rnd_%0d", i), $urandom, 1'($urandom), size, 4'($urandom),
                    $urandom, int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0),
                    $urandom);
            if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 2)));
        end
    endtask

    task automatic test_reset_in_access();
        int k;
        PREADY = 1'b0;
        HSEL = 1'b1; HADDR = 32'h50; HWRITE = 1'b0; HSIZE = 3'd2; HPROT = 4'h1; HTRANS = 2'b10;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        k = 0;
        while (!(PSEL === 1'b1 && PENABLE === 1'b1) && k < 10) begin
            @(posedge HCLK); #1;
            k++;
        end
        n_cmp++;
        if (!(PSEL === 1'b1 && PENABLE === 1'b1)) begin
            n_fail++;
            $display("FAIL rst_access_reach: PSEL/PENABLE=%b%b want 11", PSEL, PENABLE);
        end
        #2 HRESET = 1'b1;
        #1;
        n_cmp++;
        if ({PSEL, PENABLE, HREADYOUT, HRESP} !== 4'b0010) begin
            n_fail++;
            $display("FAIL rst_access_async: PSEL/PENABLE/HREADYOUT/HRESP=%b%b%b%b want 0010",
                     PSEL, PENABLE, HREADYOUT, HRESP);
        end
        @(posedge HCLK); #3;
        HRESET = 1'b0;
        exp_hrdata = 32'h0;
        @(posedge HCLK); #1;
        do_xfer("post_reset_wr", 32'h58, 1'b1, 3'd2, 4'h2, 32'h600D_D00D, 1, 1'b0, 32'h0);
        do_xfer("post_reset_rd", 32'h5C, 1'b0, 3'd2, 4'h0, 32'h0, 0, 1'b0, 32'h0DDB_A11E);
    endtask

    initial begin
        HRESET = 1'b1;
        HSEL = 1'b0; HADDR = 32'h0; HWDATA = 32'h0; HWRITE = 1'b0; HSIZE = 3'd0;
        HTRANS = 2'b00; HPROT = 4'h0; PRDATA = 32'h0; PREADY = 1'b0; PSLVERR = 1'b0;
        exp_hrdata = 32'h0;
        #12;
        test_reset();
        test_spec_cases();
        test_size_error();
        test_ignored();
        test_random();
        idle_cycles(2);
        test_reset_in_access();
        idle_cycles(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
